poly_invntt_tomont_seq: RTL and testbench

- Sequential inverse NTT (Gentleman–Sande) with Montgomery scaling for Dilithium. It is the stage directly downstream of the row accumulator.
- It consumes one 256-coefficient polynomial in NTT domain, as produced per matrix row by polyvecl_pointwise_acc_montgomery. It returns the normal-domain polynomial multiplied by 2^32 mod q (tomont).
- Computes one butterfly per cycle, then one scaling multiply per cycle. Uses the same rtr/rts handshake as the neighbouring stages.

---
 rtl/dilithium_pkg.sv | 55 +++++
 rtl/poly_invntt_tomont_seq_if.sv | 16 +
 rtl/montgomery_reduce.sv | 17 +
 rtl/poly_invntt_tomont_seq.sv | 97 +++++++++
 tb/tb_poly_invntt_tomont_seq.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, the reference zetas table and the inverse-NTT FSM encoding.
package dilithium_pkg;

  localparam int          N    = 256;
  localparam logic [31:0] Q    = 32'd8380417;
  localparam logic [63:0] Q64  = 64'd8380417;
  localparam logic [31:0] QINV = 32'd58728449;
  localparam logic [31:0] F    = 32'd41978;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    LOAD  = 3'd2,
    BFLY  = 3'd3,
    SCALE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Montgomery-form powers of the 512th root 1753 in bit-reversed order, centred.
  localparam logic signed [31:0] ZETAS [0:255] = '{
           0,    25847, -2608894,  -518909,   237124,  -777960,  -876248,   466468,
     1826347,  2353451,  -359251, -2091905,  3119733, -2884855,  3111497,  2680103,
     2725464,  1024112, -1079900,  3585928,  -549488, -1119584,  2619752, -2108549,
    -2118186, -3859737, -1399561, -3277672,  1757237,   -19422,  4010497,   280005,
     2706023,    95776,  3077325,  3530437, -1661693, -3592148, -2537516,  3915439,
    -3861115, -3043716,  3574422, -2867647,  3539968,  -300467,  2348700,  -539299,
    -1699267, -1643818,  3505694, -3821735,  3507263, -2140649, -1600420,  3699596,
      811944,   531354,   954230,  3881043,  3900724, -2556880,  2071892, -2797779,
    -3930395, -1528703, -3677745, -3041255, -1452451,  3475950,  2176455, -1585221,
    -1257611,  1939314, -4083598, -1000202, -3190144, -3157330, -3632928,   126922,
     3412210,  -983419,  2147896,  2715295, -2967645, -3693493,  -411027, -2477047,
     -671102, -1228525,   -22981, -1308169,  -381987,  1349076,  1852771, -1430430,
    -3343383,   264944,   508951,  3097992,    44288, -1100098,   904516,  3958618,
    -3724342,    -8578,  1653064, -3249728,  2389356,  -210977,   759969, -1316856,
      189548, -3553272,  3159746, -1851402, -2409325,  -177440,  1315589,  1341330,
     1285669, -1584928,  -812732, -1439742, -3019102, -3881060, -3628969,  3839961,
     2091667,  3407706,  2316500,  3817976, -3342478,  2244091, -2446433, -3562462,
      266997,  2434439, -1235728,  3513181, -3520352, -3759364, -1197226, -3193378,
      900702,  1859098,   909542,   819034,   495491, -1613174,   -43260,  -522500,
     -655327, -3122442,  2031748,  3207046, -3556995,  -525098,  -768622, -3595838,
      342297,   286988, -2437823,  4108315,  3437287, -3342277,  1735879,   203044,
     2842341,  2691481, -2590150,  1265009,  4055324,  1247620,  2486353,  1595974,
    -3767016,  1250494,  2635921, -3548272, -2994039,  1869119,  1903435, -1050970,
    -1333058,  1237275, -3318210, -1430225,  -451100,  1312455,  3306115, -1962642,
    -1279661,  1917081, -2546312, -1374803,  1500165,   777191,  2235880,  3406031,
     -542412, -2831860, -1671176, -1846953, -2584293, -3724270,   594136, -3776993,
    -2013608,  2432395,  2454455,  -164721,  1957272,  3369112,   185531, -1207385,
    -3183426,   162844,  1616392,  3014001,   810149,  1652634, -3694233, -1799107,
    -3038916,  3523897,  3866901,   269760,  2213111,  -975884,  1717735,   472078,
     -426683,  1723600, -1803090,  1910376, -1667432, -1104333,  -260646, -3833893,
    -2939036, -2235985,  -420899, -2286327,   183443,  -976891,  1612842, -3545687,
     -554416,  3919660,   -48306, -1362209,  3937738,  1400424,  -846154,  1976782
  };

endpackage

// File: rtl/poly_invntt_tomont_seq_if.sv
// Polynomial hand-off between the row accumulator, the inverse NTT and its consumer.
interface poly_invntt_tomont_seq_if;
  import dilithium_pkg::*;

  // rtr: upstream asserts it while linear_a is valid; it is sampled in WAIT and
  // linear_a must stay stable until the following LOAD edge. rts: linear_c is a
  // valid result while high; it stays high until rtr falls, and a new job needs
  // rtr to fall and rise again.
  logic             rtr;
  logic [N*32-1:0]  linear_a;
  logic [N*32-1:0]  linear_c;
  logic             rts;

  modport master (output rtr, output linear_a, input linear_c, input rts);
  modport slave  (input rtr, input linear_a, output linear_c, output rts);
endinterface

// File: rtl/montgomery_reduce.sv
// Combinational Montgomery reduction: r = (x - u*Q) >>> 32 with u = low32(x*QINV).
module montgomery_reduce
  import dilithium_pkg::*;
(
  input  logic signed [63:0] x,
  output logic signed [31:0] r
);
  logic [31:0] u;
  logic [63:0] uq;
  logic [31:0] unused_low;

  // Only the low word of x*QINV matters, so a 32x32 multiply is enough.
  assign u  = x[31:0] * QINV;
  assign uq = {{32{u[31]}}, u} * Q64;
  // The low word of x - u*Q is zero by construction; the shift keeps the high word.
  assign {r, unused_low} = x - uq;
endmodule

// File: rtl/poly_invntt_tomont_seq.sv
// Sequential Gentleman-Sande inverse NTT with Montgomery scaling: one butterfly, then one scale, per cycle.
module poly_invntt_tomont_seq
  import dilithium_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  poly_invntt_tomont_seq_if.slave bus,
  output state_t state
);
  state_t      state_next;
  logic [2:0]  l;
  logic [6:0]  b;
  logic [7:0]  idx;
  logic [31:0] coef [N];

  logic [7:0]  len, j, p, k;
  logic [6:0]  g;
  logic [31:0] zeta, t, v, sum, diff, bfly_r, scale_src, scale_r;
  logic [63:0] bfly_x, scale_x;
  logic        last_bfly;

  // Butterfly addressing: group g of size 2*len, offset within the group from b's low bits.
  assign len  = 8'd1 << l;
  assign g    = b >> l;
  assign j    = ({1'b0, g} << ({1'b0, l} + 4'd1)) | ({1'b0, b} & (len - 8'd1));
  assign p    = j + len;
  assign k    = (8'hFF >> l) - {1'b0, g};
  assign zeta = -ZETAS[k];

  assign t      = coef[j];
  assign v      = coef[p];
  assign sum    = t + v;
  assign diff   = t - v;
  assign bfly_x = {{32{zeta[31]}}, zeta} * {{32{diff[31]}}, diff};

  assign scale_src = coef[idx];
  assign scale_x   = {{32{scale_src[31]}}, scale_src} * {32'd0, F};

  assign last_bfly = (l == 3'd7) && (b == 7'd127);

  montgomery_reduce u_mont_bfly  (.x(bfly_x),  .r(bfly_r));
  montgomery_reduce u_mont_scale (.x(scale_x), .r(scale_r));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = WAIT;
      WAIT:    state_next = bus.rtr ? LOAD : WAIT;
      LOAD:    state_next = BFLY;
      BFLY:    state_next = last_bfly ? SCALE : BFLY;
      SCALE:   state_next = (idx == 8'd255) ? DONE : SCALE;
      DONE:    state_next = bus.rtr ? DONE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.rts = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) coef[i] <= '0;
      l   <= '0;
      b   <= '0;
      idx <= '0;
    end else begin
      case (state)
        LOAD: begin
          for (int i = 0; i < N; i++) coef[i] <= bus.linear_a[32*i +: 32];
          l <= '0;
          b <= '0;
        end
        BFLY: begin
          coef[j] <= sum;
          coef[p] <= bfly_r;
          b       <= b + 7'd1;
          if (b == 7'd127) l <= l + 3'd1;
          if (last_bfly) idx <= '0;
        end
        SCALE: begin
          coef[idx] <= scale_r;
          idx       <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign bus.linear_c[32*i +: 32] = coef[i];
  end

endmodule

// File: tb/tb_poly_invntt_tomont_seq.sv
// Directed/random bench for poly_invntt_tomont_seq against a C-style invntt_tomont reference model.
module tb_poly_invntt_tomont_seq;
  import dilithium_pkg::*;

  localparam longint MQ    = 8380417;
  localparam longint MQINV = 58728449;
  localparam longint MF    = 41978;
  localparam longint MMONT = 4193792;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  poly_invntt_tomont_seq_if bus();
  state_t state;

  poly_invntt_tomont_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  logic signed [63:0] mr_x;
  logic signed [31:0] mr_r;
  montgomery_reduce u_mr (.x(mr_x), .r(mr_r));

  int checks = 0;
  int errors = 0;
  logic [N*32-1:0] exp_q[$];
  int m [256];
  int zetas_m [256];
  int pin [256];

  // ---------------- reference model ----------------
  function automatic int mont(longint x);
    int u;
    longint d;
    u = int'(x * MQINV);
    d = x - longint'(u) * MQ;
    return int'(d >>> 32);
  endfunction

  function automatic int centre(longint x);
    longint r;
    r = x % MQ;
    if (r < 0) r += MQ;
    if (r > MQ / 2) r -= MQ;
    return int'(r);
  endfunction

  function automatic int brv8(int x);
    int r = 0;
    for (int i = 0; i < 8; i++) if (x[i]) r |= 1 << (7 - i);
    return r;
  endfunction

  function automatic longint powmod(longint base, int e);
    longint r = 1;
    longint bb = base % MQ;
    while (e > 0) begin
      if (e[0]) r = (r * bb) % MQ;
      bb = (bb * bb) % MQ;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic model_invntt();
    int kk, jj, start, len, t, zeta, d;
    kk = 256;
    for (len = 1; len < 256; len = len << 1) begin
      for (start = 0; start < 256; start = jj + len) begin
        kk--;
        zeta = -zetas_m[kk];
        for (jj = start; jj < start + len; jj++) begin
          t = m[jj];
          d = t - m[jj+len];
          m[jj] = t + m[jj+len];
          m[jj+len] = mont(longint'(zeta) * longint'(d));
        end
      end
    end
    for (int i = 0; i < 256; i++) m[i] = mont(MF * longint'(m[i]));
  endtask

  task automatic model_ntt();
    int kk, jj, start, len, t, zeta;
    kk = 0;
    for (len = 128; len > 0; len = len >> 1) begin
      for (start = 0; start < 256; start = jj + len) begin
        kk++;
        zeta = zetas_m[kk];
        for (jj = start; jj < start + len; jj++) begin
          t = mont(longint'(zeta) * longint'(m[jj+len]));
          m[jj+len] = m[jj] - t;
          m[jj] = m[jj] + t;
        end
      end
    end
  endtask

  task automatic golden(input logic [N*32-1:0] vec, output logic [N*32-1:0] res);
    for (int i = 0; i < 256; i++) m[i] = int'(vec[32*i +: 32]);
    model_invntt();
    for (int i = 0; i < 256; i++) res[32*i +: 32] = m[i];
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [N*32-1:0] exp);
    int bad = -1;
    for (int i = 0; i < 256; i++)
      if (bad < 0 && bus.linear_c[32*i +: 32] !== exp[32*i +: 32]) bad = i;
    if (bad < 0) bad = 0;
    checks++;
    assert (bus.linear_c === exp) else begin
      errors++;
      $error("FAIL %s coeff %0d: observed %0d expected %0d", tag, bad,
             $signed(bus.linear_c[32*bad +: 32]), $signed(exp[32*bad +: 32]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_vec(output logic [N*32-1:0] v);
    int c;
    for (int i = 0; i < 256; i++) begin
      c = int'($urandom_range(32'd16760832, 32'd0)) - 8380416;
      v[32*i +: 32] = c;
    end
  endtask

  task automatic wait_for_wait(input string tag);
    int guard = 0;
    @(negedge clock);
    while (state !== WAIT && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "_wait"}, state, WAIT);
  endtask

  task automatic run_job(input string tag, input logic [N*32-1:0] vec);
    int lat;
    logic [N*32-1:0] exp;
    golden(vec, exp);
    exp_q.push_back(exp);
    bus.rtr = 1'b0;
    wait_for_wait(tag);
    bus.linear_a = vec;
    bus.rtr = 1'b1;
    @(posedge clock);
    lat = 0;
    do begin
      @(posedge clock);
      lat++;
      #1;
    end while (bus.rts !== 1'b1 && lat < 2000);
    check({tag, "_lat"}, lat, 1281);
    check_vec({tag, "_c"}, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N*32-1:0] vec, snap;
    int hold_rts, hold_c, idle_cnt, cong;
    longint got, want;

    bus.rtr = 1'b0;
    bus.linear_a = '0;
    mr_x = '0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) zetas_m[i] = centre(MMONT * powmod(1753, brv8(i)));

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_state", state, IDLE);
    check("rst_rts", bus.rts, 0);
    check_vec("rst_c", '0);

    mr_x = 64'sd0;           #1; check("mont_zero", mr_r, 0);
    mr_x = 64'sd4294967296;  #1; check("mont_r", mr_r, 1);
    mr_x = 64'sd8380417;     #1; check("mont_q", mr_r, 0);
    mr_x = -64'sd4294967296; #1; check("mont_neg_r", mr_r, -1);

    @(negedge clock);
    reset = 1'b0;

    run_job("zero", '0);

    // Result must hold while rtr stays high.
    snap = bus.linear_c;
    hold_rts = 0;
    hold_c = 0;
    repeat (50) begin
      @(negedge clock);
      if (bus.rts === 1'b1) hold_rts++;
      if (bus.linear_c === snap) hold_c++;
    end
    check("hold_rts", hold_rts, 50);
    check("hold_c", hold_c, 50);

    bus.rtr = 1'b0;
    @(posedge clock); #1;
    check("drop_rts", bus.rts, 0);
    check("drop_idle", state, IDLE);
    @(posedge clock); #1;
    check("drop_wait", state, WAIT);
    idle_cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (state === WAIT && bus.rts === 1'b0) idle_cnt++;
    end
    check("no_restart", idle_cnt, 20);

    for (int n = 0; n < 20; n++) begin
      rand_vec(vec);
      run_job($sformatf("rand%0d", n), vec);
    end

    // Round trip through the forward NTT.
    for (int i = 0; i < 256; i++) begin
      pin[i] = int'($urandom_range(32'd16760832, 32'd0)) - 8380416;
      m[i] = pin[i];
    end
    model_ntt();
    for (int i = 0; i < 256; i++) vec[32*i +: 32] = centre(longint'(m[i]));
    run_job("rtrip", vec);
    cong = 0;
    for (int i = 0; i < 256; i++) begin
      got  = centre(longint'($signed(bus.linear_c[32*i +: 32])));
      want = centre(longint'(pin[i]) * MMONT);
      if (got == want) cong++;
    end
    check("rtrip_cong", cong, 256);

    // Abort mid-butterfly with reset.
    rand_vec(vec);
    bus.rtr = 1'b0;
    wait_for_wait("abort");
    bus.linear_a = vec;
    bus.rtr = 1'b1;
    @(posedge clock);
    repeat (501) @(posedge clock);
    #1;
    check("abort_bfly", state, BFLY);
    @(negedge clock);
    reset = 1'b1;
    bus.rtr = 1'b0;
    @(posedge clock); #1;
    check("abort_rts", bus.rts, 0);
    check("abort_state", state, IDLE);
    check_vec("abort_c", '0);
    @(negedge clock);
    reset = 1'b0;
    rand_vec(vec);
    run_job("post_abort", vec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
